// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - frame timing and pixel-pair address bus between scheduler and BMP writer
interface frame_scheduler_if #(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512
);
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH / 2) : 1;
    localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT);

    logic          start;
    logic          stall;
    logic          vertical_Pulse;
    logic          horizontal_Pulse;
    logic [RW-1:0] row_Index;
    logic [CW-1:0] col_Index;
    logic [AW-1:0] pixel_Address;
    logic          busy;
    logic          frame_Done;

    modport master (
        input  start, stall,
        output vertical_Pulse, horizontal_Pulse, row_Index, col_Index,
               pixel_Address, busy, frame_Done
    );

    modport slave (
        output start, stall,
        input  vertical_Pulse, horizontal_Pulse, row_Index, col_Index,
               pixel_Address, busy, frame_Done
    );
endinterface

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - frame timing FSM strobing one pixel pair per cycle into the BMP writer
module frame_scheduler #(
    parameter int IMAGE_WIDTH    = 768,
    parameter int IMAGE_HEIGHT   = 512,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160
) (
    input  logic clk,
    input  logic reset,
    frame_scheduler_if.master bus
);
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH / 2) : 1;
    localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam int MAX_DELAY = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int DW = $clog2(MAX_DELAY + 1);

    localparam logic [DW-1:0] VSYNC_LAST = DW'(START_UP_DELAY - 1);
    localparam logic [DW-1:0] HSYNC_LAST = DW'(HSYNC_DELAY - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH / 2 - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, HSYNC, DATA, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          vpulse_q, vpulse_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fire;

    assign fire = (state_q == DATA) && !bus.stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = VSYNC;
                    cnt_d   = '0;
                end
            end
            VSYNC: begin
                if (cnt_q == VSYNC_LAST) begin
                    state_d = HSYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            HSYNC: begin
                if (cnt_q == HSYNC_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            DATA: begin
                // Pairs are contiguous across line ends, so the address simply steps by 2
                if (fire) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + RW'(1);
                            addr_d  = addr_q + AW'(2);
                            state_d = HSYNC;
                        end
                    end else begin
                        col_d  = col_q + CW'(1);
                        addr_d = addr_q + AW'(2);
                    end
                end
            end
            DONE: begin
                row_d   = '0;
                col_d   = '0;
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        vpulse_d = (state_d == VSYNC);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            vpulse_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            vpulse_q <= vpulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.horizontal_Pulse = fire;
    assign bus.vertical_Pulse   = vpulse_q;
    assign bus.row_Index        = row_q;
    assign bus.col_Index        = col_q;
    assign bus.pixel_Address    = addr_q;
    assign bus.busy             = busy_q;
    assign bus.frame_Done       = done_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - directed bench for frame_scheduler at W=8 H=4 SUD=3 HSD=2
module tb_frame_scheduler;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    frame_scheduler_if #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(4)) bus ();

    frame_scheduler #(
        .IMAGE_WIDTH(8),
        .IMAGE_HEIGHT(4),
        .START_UP_DELAY(3),
        .HSYNC_DELAY(2)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle c is observed after edge c-1; the edge sampling start is cycle 0.
    task automatic run_frame(input int sa, input int sl);
        int pulses;
        int dones;
        int e;
        int n;
        logic exp_p;
        pulses = 0;
        dones  = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 36 + sl; c++) begin
            bus.stall = (c >= sa) && (c < sa + sl);
            #1;
            e = (c < sa) ? c : ((c < sa + sl) ? -1 : c - sl);
            exp_p = (e >= 6) && (e <= 27) && (((e - 6) % 6) < 4);
            check("hpulse", bus.horizontal_Pulse, exp_p);
            check("vpulse", bus.vertical_Pulse, (c >= 1) && (c <= 3));
            check("busy", bus.busy, c <= 28 + sl);
            check("frame_done", bus.frame_Done, c == 28 + sl);
            if (exp_p) begin
                n = ((e - 6) / 6) * 4 + (e - 6) % 6;
                check("row", bus.row_Index, n / 4);
                check("col", bus.col_Index, n % 4);
                check("addr", bus.pixel_Address, 8 * (n / 4) + 2 * (n % 4));
            end
            if (e == -1) begin
                n = ((sa - 6) / 6) * 4 + (sa - 6) % 6;
                check("stall_row", bus.row_Index, n / 4);
                check("stall_col", bus.col_Index, n % 4);
                check("stall_addr", bus.pixel_Address, 8 * (n / 4) + 2 * (n % 4));
            end
            if (bus.horizontal_Pulse) pulses++;
            if (bus.frame_Done) dones++;
            step();
        end
        bus.stall = 1'b0;
        check("pulse_count", pulses, 16);
        check("done_count", dones, 1);
    endtask

    initial begin
        int k;
        tests = 0;
        fails = 0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_vpulse", bus.vertical_Pulse, 0);
        check("rst_hpulse", bus.horizontal_Pulse, 0);
        check("rst_row", bus.row_Index, 0);
        check("rst_col", bus.col_Index, 0);
        check("rst_addr", bus.pixel_Address, 0);
        check("rst_done", bus.frame_Done, 0);
        rst = 1'b0;
        step();

        run_frame(1000, 0);
        run_frame(13, 5);

        // start held high: busy through DONE at 28, one idle cycle, VSYNC again from 30
        bus.start = 1'b1;
        step();
        for (int c = 1; c <= 33; c++) begin
            check("held_busy", bus.busy, (c <= 28) || (c >= 30));
            check("held_vpulse", bus.vertical_Pulse, ((c >= 1) && (c <= 3)) || ((c >= 30) && (c <= 32)));
            check("held_done", bus.frame_Done, c == 28);
            step();
        end
        bus.start = 1'b0;
        k = 0;
        while (!bus.frame_Done && k < 60) begin
            step();
            k++;
        end
        check("frame2_done", bus.frame_Done, 1);
        step();
        check("frame2_idle", bus.busy, 0);
        repeat (3) step();
        check("no_requeue", bus.busy, 0);

        // reset in the middle of line 2
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (18) step();
        check("pre_rst_hpulse", bus.horizontal_Pulse, 1);
        check("pre_rst_row", bus.row_Index, 2);
        check("pre_rst_col", bus.col_Index, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_hpulse", bus.horizontal_Pulse, 0);
        check("arst_row", bus.row_Index, 0);
        check("arst_col", bus.col_Index, 0);
        check("arst_addr", bus.pixel_Address, 0);
        check("arst_vpulse", bus.vertical_Pulse, 0);
        check("arst_done", bus.frame_Done, 0);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            check("post_rst_done", bus.frame_Done, 0);
            check("post_rst_busy", bus.busy, 0);
        end

        run_frame(1000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences one image frame into the BMP write datapath.
- On `start`, it produces the frame timing:
  - a start-up vertical pulse window,
  - per-line horizontal blanking,
  - one `horizontal_Pulse` per pixel pair (even/odd).
- Presents the row, pair-column and source pixel address of the pair currently strobed, so the source memory and the writer stay in lockstep.
- Sits between the image source (pixel memory/processing stage) and the BMP writer, driving its `horizontal_Pulse`.

Parameters:
- IMAGE_WIDTH, 768, pixels per line; must be even, ≥2.
- IMAGE_HEIGHT, 512, lines per frame, ≥1.
- START_UP_DELAY, 100, cycles of vertical pulse before the first line, ≥1.
- HSYNC_DELAY, 160, blanking cycles before every line, ≥1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- start  in  1  frame request; sampled only in IDLE.
- stall  in  1  downstream/source hold; honoured only in DATA.
- vertical_Pulse  out  1  high throughout VSYNC.
- horizontal_Pulse  out  1  pixel-pair strobe; combinational: (state==DATA) & ~stall.
- row_Index  out  $clog2(IMAGE_HEIGHT)  current line, 0 = top.
- col_Index  out  $clog2(IMAGE_WIDTH/2)  current pair within line.
- pixel_Address  out  $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)  row_Index*IMAGE_WIDTH + 2*col_Index (even pixel); odd pixel is +1.
- busy  out  1  high in every state except IDLE.
- frame_Done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal delay counter 0.
- States and transitions:
  - IDLE: start=1 → VSYNC, delay counter cleared.
  - VSYNC: vertical_Pulse=1; counts START_UP_DELAY cycles → HSYNC, counter cleared.
  - HSYNC: counts HSYNC_DELAY cycles → DATA.
  - DATA: each cycle with stall=0 fires horizontal_Pulse, then advances col_Index.
    - At col_Index==IMAGE_WIDTH/2-1 with a fire: col_Index←0.
    - If row_Index==IMAGE_HEIGHT-1 → DONE; else row_Index+1 and → HSYNC.
  - DONE: frame_Done=1 for exactly one cycle; row/col cleared → IDLE.
- Stall in DATA: no pulse; row/col/address frozen; no limit on stall length.
- Stall outside DATA has no effect.
- Latency (unstalled):
  - Edge that samples start = cycle 0.
  - First horizontal_Pulse in cycle START_UP_DELAY+HSYNC_DELAY+1.
  - Total busy cycles = START_UP_DELAY + IMAGE_HEIGHT*(HSYNC_DELAY+IMAGE_WIDTH/2) + 1.
- Pulses per frame = IMAGE_HEIGHT*IMAGE_WIDTH/2 exactly (196608 at defaults); stalls never add or drop pulses.
- pixel_Address: registered, updated with row/col, never exceeds IMAGE_WIDTH*IMAGE_HEIGHT-2.
- start while busy (incl. DONE cycle): ignored, not queued.
- start held high continuously: a new frame begins on the first IDLE cycle after DONE (one idle cycle between frames).
- Reset asserted mid-frame: immediate return to IDLE, outputs 0, no frame_Done.
  - After deassertion, the block waits for a new start.
- All counters: unsigned; compare against parameter-derived constants; no wrap beyond range.

Test Plan (W=8, H=4, SUD=3, HSD=2 unless stated):
- Reset then single start pulse, stall=0 → vertical_Pulse high cycles 1-3; first horizontal_Pulse cycle 6; 16 pulses total in 4 bursts of 4 separated by 2 idle cycles; frame_Done at cycle 28; busy low from cycle 29.
- Address check, same run → pulse n carries row=n/4, col=n%4, pixel_Address=8*row+2*col (last = 30).
- stall high for 5 cycles at 2nd pulse of line 1 → no pulses during stall; col/address frozen at (1,1,10); still 16 pulses total; frame_Done delayed 5 cycles.
- start pulsed mid-frame and during DONE → ignored; start held high → second frame's VSYNC begins exactly 2 cycles after first frame_Done.
- reset asserted during line 2 → all outputs 0 asynchronously; no frame_Done; a subsequent start gives a full 16-pulse frame from row 0.
- Defaults (768×512) → exactly 196608 horizontal_Pulses; last pixel_Address 393214; one frame_Done.
